// File: rtl/bmu_search_controller.sv
// bmu_search_controller: scans the node weight memory through the shared
// ED_calculator and reports the best-matching unit and the runner-up.
module bmu_search_controller #(
  parameter int MAX_NODES = 64,
  parameter int ADDR_W    = $clog2(MAX_NODES),
  parameter int VEC_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [VEC_W-1:0]  x_in,
  input  logic [ADDR_W:0]   num_nodes,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic [VEC_W-1:0]  ed_x,
  output logic [VEC_W-1:0]  ed_w,
  input  logic [31:0]       ed_dist,
  output logic              busy,
  output logic              done,
  output logic              err_empty,
  output logic [ADDR_W-1:0] winner_idx,
  output logic [31:0]       winner_dist,
  output logic              runner_valid,
  output logic [ADDR_W-1:0] runner_idx,
  output logic [31:0]       runner_dist
);

  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(MAX_NODES);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    x_q, x_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic                w_vld_q, w_vld_d, r_vld_q, r_vld_d;
  logic [ADDR_W-1:0]   w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic [31:0]         w_dist_q, w_dist_d, r_dist_q, r_dist_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   win_idx_q, win_idx_d, run_idx_q, run_idx_d;
  logic [31:0]         win_dist_q, win_dist_d, run_dist_q, run_dist_d;
  logic                run_vld_q, run_vld_d;
  logic [ADDR_W:0]     n_clamp;
  logic                last_addr;

  assign n_clamp   = (num_nodes > MAX_N) ? MAX_N : num_nodes;
  assign last_addr = ({1'b0, addr_q} == (n_q - 1'b1));

  // State, operand, running-best and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_idx_q  <= '0;
      w_vld_q    <= 1'b0;
      w_idx_q    <= '0;
      w_dist_q   <= '0;
      r_vld_q    <= 1'b0;
      r_idx_q    <= '0;
      r_dist_q   <= '0;
      err_q      <= 1'b0;
      win_idx_q  <= '0;
      win_dist_q <= '0;
      run_vld_q  <= 1'b0;
      run_idx_q  <= '0;
      run_dist_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_idx_q  <= cmp_idx_d;
      w_vld_q    <= w_vld_d;
      w_idx_q    <= w_idx_d;
      w_dist_q   <= w_dist_d;
      r_vld_q    <= r_vld_d;
      r_idx_q    <= r_idx_d;
      r_dist_q   <= r_dist_d;
      err_q      <= err_d;
      win_idx_q  <= win_idx_d;
      win_dist_q <= win_dist_d;
      run_vld_q  <= run_vld_d;
      run_idx_q  <= run_idx_d;
      run_dist_q <= run_dist_d;
    end
  end

  // Next-state, address sequencing, compare stage and result capture
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    n_d        = n_q;
    addr_d     = addr_q;
    cmp_vld_d  = 1'b0;
    cmp_idx_d  = addr_q;
    w_vld_d    = w_vld_q;
    w_idx_d    = w_idx_q;
    w_dist_d   = w_dist_q;
    r_vld_d    = r_vld_q;
    r_idx_d    = r_idx_q;
    r_dist_d   = r_dist_q;
    err_d      = err_q;
    win_idx_d  = win_idx_q;
    win_dist_d = win_dist_q;
    run_vld_d  = run_vld_q;
    run_idx_d  = run_idx_q;
    run_dist_d = run_dist_q;

    // Compare stage: one cycle behind the address that produced mem_rdata
    if (cmp_vld_q) begin
      if (!w_vld_q || (ed_dist < w_dist_q)) begin
        r_vld_d  = w_vld_q;
        r_idx_d  = w_idx_q;
        r_dist_d = w_dist_q;
        w_vld_d  = 1'b1;
        w_idx_d  = cmp_idx_q;
        w_dist_d = ed_dist;
      end else if (!r_vld_q || (ed_dist < r_dist_q)) begin
        r_vld_d  = 1'b1;
        r_idx_d  = cmp_idx_q;
        r_dist_d = ed_dist;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          x_d      = x_in;
          n_d      = n_clamp;
          addr_d   = '0;
          w_vld_d  = 1'b0;
          w_idx_d  = '0;
          w_dist_d = '0;
          r_vld_d  = 1'b0;
          r_idx_d  = '0;
          r_dist_d = '0;
          err_d    = (n_clamp == '0);
          state_d  = (n_clamp == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cmp_vld_d = 1'b1;
          if (last_addr) state_d = DRAIN;
          else           addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = abort ? IDLE : FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Results are taken from the post-compare values so the last read counts
    if (state_d == FINISH) begin
      win_idx_d  = w_vld_d ? w_idx_d  : '0;
      win_dist_d = w_vld_d ? w_dist_d : '0;
      run_vld_d  = r_vld_d;
      run_idx_d  = r_vld_d ? r_idx_d  : '0;
      run_dist_d = r_vld_d ? r_dist_d : '0;
    end
  end

  assign mem_rd_en    = (state_q == SCAN);
  assign mem_addr     = addr_q;
  assign ed_x         = x_q;
  assign ed_w         = cmp_vld_q ? mem_rdata : '0;
  assign busy         = (state_q == SCAN) || (state_q == DRAIN);
  assign done         = (state_q == FINISH);
  assign err_empty    = err_q;
  assign winner_idx   = win_idx_q;
  assign winner_dist  = win_dist_q;
  assign runner_valid = run_vld_q;
  assign runner_idx   = run_idx_q;
  assign runner_dist  = run_dist_q;

endmodule
